// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - writeback arbiter (ALU/LSU) and RAW scoreboard for the register-file write port
// Define RR_ARB_EN for round-robin arbitration; default build gives the LSU fixed priority.
module regfile_wb_scheduler #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            stall,
  output logic            w_en,
  output logic [AW-1:0]   w_addr,
  output logic [XLEN-1:0] w_data
);

  logic            grant_alu;
  logic            grant_lsu;
  logic            grant_any;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;

  logic            w_en_q,   w_en_d;
  logic [AW-1:0]   w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic [NREG-1:0] pending_q, pending_d;

`ifdef RR_ARB_EN
  // 1 when the LSU took the most recent grant; reset leaves the ALU as last winner.
  logic last_lsu_q, last_lsu_d;

  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (rst) begin
      if (alu_valid && lsu_valid) begin
        grant_lsu = ~last_lsu_q;
        grant_alu = last_lsu_q;
      end else begin
        grant_alu = alu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (grant_lsu) begin
      last_lsu_d = 1'b1;
    end else if (grant_alu) begin
      last_lsu_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
`else
  assign grant_lsu = rst & lsu_valid;
  assign grant_alu = rst & alu_valid & ~lsu_valid;
`endif

  assign grant_any = grant_alu | grant_lsu;
  assign win_addr  = grant_lsu ? lsu_addr : alu_addr;
  assign win_data  = grant_lsu ? lsu_data : alu_data;

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  // A grant to x0 is consumed but leaves the write port idle and its address/data untouched.
  always_comb begin
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (grant_any && (win_addr != '0)) begin
      w_en_d   = 1'b1;
      w_addr_d = win_addr;
      w_data_d = win_data;
    end
  end

  // Clear before set so an issue to the register being written keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (grant_any && (win_addr != '0)) begin
      pending_d[win_addr] = 1'b0;
    end
    if (iss_en && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_en_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      pending_q <= '0;
    end else begin
      w_en_q    <= w_en_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      pending_q <= pending_d;
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

  assign rs1_busy = rst & pending_q[rs1];
  assign rs2_busy = rst & pending_q[rs2];
  assign stall    = rs1_busy | rs2_busy | (alu_valid & ~alu_ready);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed plus randomized checks of regfile_wb_scheduler against a behavioural model
module tb_regfile_wb_scheduler;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid;
  logic [AW-1:0]   alu_addr;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_addr;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [XLEN-1:0] w_data;

  regfile_wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_addr(lsu_addr), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_en(iss_en), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: set of pending registers and the expected write-port contents.
  bit              pend [NREG];
  bit              exp_wen;
  int unsigned     exp_waddr;
  int unsigned     exp_wdata;
  bit              last_was_lsu;
  bit              g_alu, g_lsu;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    exp_wen      = 1'b0;
    exp_waddr    = 0;
    exp_wdata    = 0;
    last_was_lsu = 1'b0;
  endtask

  // One cycle: check mid-cycle, advance the model, then cross the edge.
  task automatic step();
    int unsigned a;
    #4;
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (rst) begin
      if (alu_valid && lsu_valid) begin
`ifdef RR_ARB_EN
        if (last_was_lsu) g_alu = 1'b1; else g_lsu = 1'b1;
`else
        g_lsu = 1'b1;
`endif
      end else begin
        g_alu = alu_valid;
        g_lsu = lsu_valid;
      end
    end
    chk("alu_ready", alu_ready, g_alu);
    chk("lsu_ready", lsu_ready, g_lsu);
    chk("rs1_busy", rs1_busy, rst && pend[rs1]);
    chk("rs2_busy", rs2_busy, rst && pend[rs2]);
    chk("stall", stall, (rst && (pend[rs1] || pend[rs2])) || (alu_valid && !g_alu));
    chk("w_en", w_en, exp_wen);
    chk("w_addr", w_addr, exp_waddr);
    chk("w_data", w_data, exp_wdata);
    if (!rst) begin
      model_reset();
    end else begin
      exp_wen = 1'b0;
      if (g_alu || g_lsu) begin
        last_was_lsu = g_lsu;
        a = g_lsu ? lsu_addr : alu_addr;
        if (a != 0) begin
          exp_wen   = 1'b1;
          exp_waddr = a;
          exp_wdata = g_lsu ? lsu_data : alu_data;
          pend[a]   = 1'b0;
        end
      end
      if (iss_en && iss_rd != 0) pend[iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    iss_en = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with a pending ALU request.
    step();
    step();
    chk("reset_wen", w_en, 1'b0);
    rst = 1'b1;
    step();
    chk("single_wen", w_en, 1'b1);
    chk("single_addr", w_addr, 5'd5);
    chk("single_data", w_data, 32'hDEADBEEF);
    alu_valid = 1'b0;
    step();
    chk("single_idle", w_en, 1'b0);

    // Conflict: each side drops after its own grant.
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      if (g_alu) alu_valid = 1'b0;
      if (g_lsu) lsu_valid = 1'b0;
    end
    // Second conflict, both held continuously.
    alu_valid = 1'b1; lsu_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();

    // Scoreboard RAW on r7.
    iss_en = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    step();
    iss_en = 1'b0;
    chk("sb_busy_set", rs1_busy, 1'b1);
    lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hCAFE0007;
    step();
    lsu_valid = 1'b0;
    chk("sb_busy_clr", rs1_busy, 1'b0);
    chk("sb_waddr", w_addr, 5'd7);

    // Issue and write of r9 in the same cycle keeps r9 pending.
    iss_en = 1'b1; iss_rd = 5'd9; rs2 = 5'd9;
    step();
    lsu_valid = 1'b1; lsu_addr = 5'd9; lsu_data = 32'h99;
    step();
    iss_en = 1'b0; lsu_valid = 1'b0;
    chk("set_wins", rs2_busy, 1'b1);

    // Write to x0 and issue to x0.
    alu_valid = 1'b1; alu_addr = '0; alu_data = 32'h12345678;
    iss_en = 1'b1; iss_rd = '0; rs1 = '0;
    step();
    alu_valid = 1'b0; iss_en = 1'b0;
    chk("x0_wen", w_en, 1'b0);
    chk("x0_busy", rs1_busy, 1'b0);

    // Reset in the cycle a write would be granted.
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66; rst = 1'b0;
    step();
    rst = 1'b1; alu_valid = 1'b0;
    chk("midrst_wen", w_en, 1'b0);
    chk("midrst_busy", rs2_busy, 1'b0);
    step();

    // Randomized traffic obeying the valid/ready hold rule.
    for (int n = 0; n < 600; n++) begin
      rst    = ($urandom_range(0, 59) != 0);
      iss_en = $urandom_range(0, 1);
      iss_rd = AW'($urandom_range(0, NREG - 1));
      rs1    = AW'($urandom_range(0, NREG - 1));
      rs2    = AW'($urandom_range(0, NREG - 1));
      step();
      if (!alu_valid || g_alu) begin
        alu_valid = $urandom_range(0, 1);
        alu_addr  = AW'($urandom_range(0, NREG - 1));
        alu_data  = $urandom;
      end
      if (!lsu_valid || g_lsu) begin
        lsu_valid = ($urandom_range(0, 2) == 0);
        lsu_addr  = AW'($urandom_range(0, NREG - 1));
        lsu_data  = $urandom;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
